// File: rtl/block_deserialiser.sv
// Packs an incoming byte stream into a 4x4 block of 32-bit words.
// Single block buffer with valid/ready on both sides. A short final block
// is padded with PAD_BYTE and reported with its byte count.
module block_deserialiser #(
    parameter logic [7:0] PAD_BYTE       = 8'h00,
    parameter bit         BYTE_MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [3:0][3:0][31:0] outdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [6:0]            out_nbytes
);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [5:0] byte_cnt;
    logic       accept;
    logic       close_blk;
    logic       release_blk;
    logic [1:0] row;
    logic [1:0] col;
    logic [4:0] lane_lsb;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake signals; in_ready is held low while rst is high
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        accept      = 1'b0;
        close_blk   = 1'b0;
        release_blk = 1'b0;
        case (state)
            FILL: begin
                in_ready  = !rst;
                accept    = in_valid && !rst;
                close_blk = accept && (in_last || (byte_cnt == 6'd63));
                if (close_blk) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid   = 1'b1;
                release_blk = out_ready;
                if (out_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Target word and byte lane of the next byte: first word lands in [3][3]
    always_comb begin
        row = 2'd3 - byte_cnt[5:4];
        col = 2'd3 - byte_cnt[3:2];
        if (BYTE_MSB_FIRST) begin
            lane_lsb = 5'd24 - {byte_cnt[1:0], 3'b000};
        end else begin
            lane_lsb = {byte_cnt[1:0], 3'b000};
        end
    end

    // Block buffer, byte counter and block descriptors
    always_ff @(posedge clk) begin
        if (rst || release_blk) begin
            byte_cnt   <= '0;
            outdata    <= {64{PAD_BYTE}};
            out_last   <= 1'b0;
            out_nbytes <= '0;
        end else if (accept) begin
            outdata[row][col][lane_lsb +: 8] <= in_byte;
            byte_cnt                         <= byte_cnt + 6'd1;
            if (close_blk) begin
                out_nbytes <= {1'b0, byte_cnt} + 7'd1;
                out_last   <= in_last;
            end
        end
    end

endmodule

// File: tb/tb_block_deserialiser.sv
// Self-checking bench for block_deserialiser: directed scenarios plus a
// randomized run, all compared against a byte-queue reference model.
module tb_block_deserialiser;

    typedef logic [3:0][3:0][31:0] blk_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;

    logic       in_ready,   in_ready_l;
    blk_t       outdata,    outdata_l;
    logic       out_valid,  out_valid_l;
    logic       out_last,   out_last_l;
    logic [6:0] out_nbytes, out_nbytes_l;

    block_deserialiser #(.PAD_BYTE(8'h00), .BYTE_MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .outdata(outdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_nbytes(out_nbytes)
    );

    block_deserialiser #(.PAD_BYTE(8'h5A), .BYTE_MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_l), .outdata(outdata_l),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_last(out_last_l),
        .out_nbytes(out_nbytes_l)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    // Reference model state
    logic [7:0]  cur[$];
    bit          pending = 1'b0;
    blk_t        exp_m, exp_l;
    logic [6:0]  exp_n;
    logic        exp_last;
    int unsigned blocks_done = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word j holds bytes 4j..4j+3 and sits at [3-j/4][3-j%4]
    function automatic blk_t build(input logic [7:0] q[$], input bit msb, input logic [7:0] pad);
        blk_t       m;
        logic [7:0] b;
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 4; k++) begin
                b = (4 * j + k < q.size()) ? q[4 * j + k] : pad;
                if (msb) m[3 - j / 4][3 - j % 4][31 - 8 * k -: 8] = b;
                else     m[3 - j / 4][3 - j % 4][8 * k +: 8]      = b;
            end
        end
        return m;
    endfunction

    // One clock: compare against the model mid-cycle, update the model, advance
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            check("in_ready_rst", in_ready, 1'b0);
            pending = 1'b0;
            cur.delete();
        end else begin
            check("out_valid", out_valid, pending);
            check("out_valid_lsb", out_valid_l, pending);
            check("in_ready", in_ready, !pending);
            check("in_ready_lsb", in_ready_l, !pending);
            if (pending) begin
                check("outdata", outdata, exp_m);
                check("outdata_lsb", outdata_l, exp_l);
                check("out_nbytes", out_nbytes, exp_n);
                check("out_nbytes_lsb", out_nbytes_l, exp_n);
                check("out_last", out_last, exp_last);
                check("out_last_lsb", out_last_l, exp_last);
                if (out_ready) begin
                    pending = 1'b0;
                    blocks_done++;
                end
            end else begin
                check("out_nbytes_idle", out_nbytes, 7'd0);
                check("out_last_idle", out_last, 1'b0);
                if (in_valid) begin
                    cur.push_back(in_byte);
                    if (in_last || cur.size() == 64) begin
                        exp_m    = build(cur, 1'b1, 8'h00);
                        exp_l    = build(cur, 1'b0, 8'h5A);
                        exp_n    = 7'(cur.size());
                        exp_last = in_last;
                        pending  = 1'b1;
                        cur.delete();
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        blk_t        src;
        logic [31:0] w;
        int unsigned target;

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outdata", outdata, '0);
        check("rst_outdata_lsb", outdata_l, {64{8'h5A}});
        check("rst_nbytes", out_nbytes, 7'd0);
        check("rst_last", out_last, 1'b0);

        // Full block 0x00..0x3F, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(8'(i), 1'b0);
        check("t1_valid", out_valid, 1'b1);
        check("t1_w33", outdata[3][3], 32'h00010203);
        check("t1_w32", outdata[3][2], 32'h04050607);
        check("t1_w00", outdata[0][0], 32'h3C3D3E3F);
        check("t1_nbytes", out_nbytes, 7'd64);
        check("t1_last", out_last, 1'b0);
        tick();
        check("t1_one_cycle", out_valid, 1'b0);

        // Short block of five bytes
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
        send(8'hEE, 1'b1);
        check("t2_w33", outdata[3][3], 32'hAABBCCDD);
        check("t2_w32", outdata[3][2], 32'hEE000000);
        check("t2_w00", outdata[0][0], 32'h00000000);
        check("t2_nbytes", out_nbytes, 7'd5);
        check("t2_last", out_last, 1'b1);
        check("t2_lsb_w33", outdata_l[3][3], 32'hDDCCBBAA);
        check("t2_lsb_w32", outdata_l[3][2], 32'h5A5A5AEE);
        tick();

        // Backpressure: block held for 10 cycles while input keeps offering
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) send(8'($urandom), 1'b0);
        in_valid = 1'b1; in_byte = 8'hEE;
        repeat (10) tick();
        check("t3_hold_valid", out_valid, 1'b1);
        check("t3_hold_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        check("t3_released", out_valid, 1'b0);
        send(8'h99, 1'b0); send(8'h98, 1'b0); send(8'h97, 1'b0); send(8'h96, 1'b1);
        check("t3_next_w33", outdata[3][3], 32'h99989796);
        check("t3_next_nbytes", out_nbytes, 7'd4);
        tick();

        // Reset in the middle of a fill
        for (int i = 0; i < 20; i++) send(8'($urandom), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) send(8'(8'h40 + i), 1'b0);
        check("t4_w33", outdata[3][3], 32'h40414243);
        check("t4_nbytes", out_nbytes, 7'd64);
        tick();

        // Random input gaps, random last, random consumer stalls
        target = blocks_done + 8;
        for (int cyc = 0; cyc < 4000 && blocks_done < target; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_byte   = 8'($urandom);
            in_last   = ($urandom_range(0, 19) == 0);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        check("t5_blocks", blocks_done >= target, 1'b1);
        check("t5_drained", out_valid, 1'b0);

        // Loopback of a known matrix serialised word [3][3] first, MSB first,
        // with in_last on byte 63
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) src[r][c] = $urandom;
        for (int j = 0; j < 16; j++) begin
            w = src[3 - j / 4][3 - j % 4];
            send(w[31:24], 1'b0);
            send(w[23:16], 1'b0);
            send(w[15:8],  1'b0);
            send(w[7:0],   j == 15);
        end
        check("t6_loopback", outdata, src);
        check("t6_nbytes", out_nbytes, 7'd64);
        check("t6_last", out_last, 1'b1);
        tick();
        check("t6_done", out_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
